pipeline_memaccess: RTL and testbench
=====================================

// Module: pipeline_memaccess
// PURPOSE
//  RV32 memory-access stage: sits between execute and writeback and also forms the MEM/WB register.
//  - Issues loads/stores to data memory over a req/ack handshake.
//  - Aligns and sign/zero-extends load data.
//  - Stalls upstream while an access is outstanding.
//  - Registers alu_result/pcsrc/offset/mem_to_reg/rd/reg_write alongside load data for writeback.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max cycles to wait for dmem_ack_i; 0 = wait forever
// PORTS
//  clk_i          in   1   clock, rising edge
//  reset_i        in   1   synchronous reset, active-high
//  valid_i        in   1   EX/MEM holds valid instruction
//  ready_o        out  1   stage can accept (low = stall upstream)
//  alu_result_i   in   32  ALU result / effective address
//  store_data_i   in   32  rs2 value for stores
//  funct3_i       in   3   access size/sign (RV32I load/store encoding)
//  mem_read_i     in   1   load
//  mem_write_i    in   1   store (mem_read_i & mem_write_i both high = illegal, treated as load)
//  pcsrc_i        in   32  PC+4 for link writeback
//  offset_i       in   32  sign-extended immediate (LUI path)
//  mem_to_reg_i   in   2   writeback mux select, passed through
//  rd_i           in   5   destination register
//  reg_write_i    in   1   register write enable
//  dmem_req_o     out  1   memory request, held until ack
//  dmem_we_o      out  1   1 = write
//  dmem_addr_o    out  32  word address {alu_result[31:2],2'b00}
//  dmem_wdata_o   out  32  lane-replicated store data
//  dmem_be_o      out  4   byte enables
//  dmem_ack_i     in   1   one-cycle completion; rdata valid same cycle
//  dmem_rdata_i   in   32  read word
//  valid_o, data_read_o[32], alu_result_o[32], pcsrc_o[32], offset_o[32], mem_to_reg_o[2],
//  rd_o[5], reg_write_o, bus_err_o    out   MEM/WB register contents for writeback
// BEHAVIOUR
//  - Reset: all registered outputs 0; state IDLE; ready_o 0 while reset_i high, 1 in IDLE after.
//  - ready_o = (state==IDLE); writeback always accepts, so there is no downstream ready.
//  - FSM IDLE: accept on valid_i&ready_o; non-mem op -> outputs loaded, valid_o=1 next cycle,
//    stay IDLE (throughput 1/cycle, data_read_o=0); mem op -> latch command, go ACCESS.
//  - FSM ACCESS: dmem_req_o=1 with stable addr/we/be/wdata. On dmem_ack_i, capture aligned
//    data, valid_o=1 next cycle, go IDLE. Minimum load/store latency is 2 cycles (accept -> valid_o).
//  - Timeout: count ACCESS cycles; at TIMEOUT_CYCLES without ack, drop req, valid_o=1 with
//    reg_write_o=0 and bus_err_o=1, go IDLE. An ack arriving in IDLE is ignored.
//  - valid_o and bus_err_o are single-cycle pulses; the other outputs hold until next load.
//  - Load: byte lane = addr[1:0], half lane = addr[1].
//    LB/LH sign-extend, LBU/LHU zero-extend, LW whole word; funct3 011/110/111 -> data_read_o=0.
//  - Store be: SB 4'b0001<<addr[1:0] with wdata={4{b}}; SH addr[1]?1100:0011 with wdata={2{h}};
//    SW 1111. Stores return data_read_o=0.
//  - Reset in ACCESS: req drops next edge, state IDLE, in-flight op discarded.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined:
//    - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, issues no request.
//    - valid_o pulses the cycle after accept with reg_write_o=0 and misalign_o=1 (extra port).
//  Not defined:
//    - No misalign_o port; low address bits below access size are ignored.
// TESTING
//  - Reset mid-ACCESS -> dmem_req_o 0 next cycle, ready_o 1 after release, late ack ignored.
//  - ALU op alu_result=0x1234, mem_to_reg=01, 3 back-to-back -> valid_o each cycle, no dmem_req_o.
//  - LB addr 0x103, rdata 0x80FF_0000, ack after 3 cycles -> data_read_o=0xFFFF_FF80,
//    ready_o low 4 cycles.
//  - SH addr 0x22 data 0xABCD -> be=1100, wdata=0xABCD_ABCD, dmem_we_o=1.
//  - No ack, TIMEOUT_CYCLES=16 -> req for 16 cycles, then valid_o, bus_err_o=1, reg_write_o=0.
//  - MISALIGN_TRAP_EN: LW addr 0x2 -> no req, misalign_o=1, reg_write_o=0.
//    Without the macro -> word read at 0x0.

Source files
------------

// File: rtl/pipeline_memaccess.sv
// RV32 memory-access stage and MEM/WB register: issues data-memory requests, aligns load data.
// Optional MISALIGN_TRAP_EN adds misalign_o and suppresses misaligned accesses.
module pipeline_memaccess #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] store_data_i,
  input  logic [2:0]  funct3_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [31:0] pcsrc_i,
  input  logic [31:0] offset_i,
  input  logic [1:0]  mem_to_reg_i,
  input  logic [4:0]  rd_i,
  input  logic        reg_write_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        valid_o,
  output logic [31:0] data_read_o,
  output logic [31:0] alu_result_o,
  output logic [31:0] pcsrc_o,
  output logic [31:0] offset_o,
  output logic [1:0]  mem_to_reg_o,
  output logic [4:0]  rd_o,
  output logic        reg_write_o,
  output logic        bus_err_o
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        misalign_o
`endif
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state_q, state_d;
  logic [31:0] timer_q;
  logic [31:0] cmd_addr_q;
  logic        cmd_we_q;
  logic [3:0]  cmd_be_q;
  logic [31:0] cmd_wdata_q;
  logic [2:0]  cmd_funct3_q;
  logic [31:0] pend_pcsrc_q;
  logic [31:0] pend_offset_q;
  logic [1:0]  pend_mem_to_reg_q;
  logic [4:0]  pend_rd_q;
  logic        pend_reg_write_q;

  logic        accept, is_mem, is_store, misaligned, ack_hit, timeout_hit;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  assign ready_o  = (state_q == IDLE) && !reset_i;
  assign accept   = valid_i && ready_o;
  assign is_mem   = mem_read_i || mem_write_i;
  // A command with both read and write set is treated as a load.
  assign is_store = mem_write_i && !mem_read_i;

`ifdef MISALIGN_TRAP_EN
  assign misaligned = is_mem &&
                      (((funct3_i[1:0] == 2'b01) && alu_result_i[0]) ||
                       ((funct3_i[1:0] == 2'b10) && (alu_result_i[1:0] != 2'b00)));
`else
  assign misaligned = 1'b0;
`endif

  assign ack_hit     = (state_q == ACCESS) && dmem_ack_i;
  assign timeout_hit = (state_q == ACCESS) && !dmem_ack_i && (TIMEOUT_CYCLES != 0) &&
                       (timer_q == TIMEOUT_CYCLES - 32'd1);

  assign dmem_req_o   = (state_q == ACCESS);
  assign dmem_we_o    = cmd_we_q;
  assign dmem_addr_o  = {cmd_addr_q[31:2], 2'b00};
  assign dmem_be_o    = cmd_be_q;
  assign dmem_wdata_o = cmd_wdata_q;

  always_comb begin
    st_be    = 4'b0000;
    st_wdata = 32'h0;
    case (funct3_i[1:0])
      2'b00: begin
        st_be    = 4'b0001 << alu_result_i[1:0];
        st_wdata = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        st_be    = alu_result_i[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{store_data_i[15:0]}};
      end
      2'b10: begin
        st_be    = 4'b1111;
        st_wdata = store_data_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_sel  = 8'h00;
    load_data = 32'h0;
    case (cmd_addr_q[1:0])
      2'd0: byte_sel = dmem_rdata_i[7:0];
      2'd1: byte_sel = dmem_rdata_i[15:8];
      2'd2: byte_sel = dmem_rdata_i[23:16];
      2'd3: byte_sel = dmem_rdata_i[31:24];
      default: ;
    endcase
    half_sel = cmd_addr_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (cmd_funct3_q)
      3'b000: load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001: load_data = {{16{half_sel[15]}}, half_sel};
      3'b010: load_data = dmem_rdata_i;
      3'b100: load_data = {24'h0, byte_sel};
      3'b101: load_data = {16'h0, half_sel};
      default: load_data = 32'h0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && is_mem && !misaligned) state_d = ACCESS;
      ACCESS:  if (ack_hit || timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Non-memory and trapped ops write back directly; memory ops wait for ack or timeout.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q           <= IDLE;
      timer_q           <= 32'h0;
      cmd_addr_q        <= 32'h0;
      cmd_we_q          <= 1'b0;
      cmd_be_q          <= 4'b0000;
      cmd_wdata_q       <= 32'h0;
      cmd_funct3_q      <= 3'b000;
      pend_pcsrc_q      <= 32'h0;
      pend_offset_q     <= 32'h0;
      pend_mem_to_reg_q <= 2'b00;
      pend_rd_q         <= 5'd0;
      pend_reg_write_q  <= 1'b0;
      valid_o           <= 1'b0;
      data_read_o       <= 32'h0;
      alu_result_o      <= 32'h0;
      pcsrc_o           <= 32'h0;
      offset_o          <= 32'h0;
      mem_to_reg_o      <= 2'b00;
      rd_o              <= 5'd0;
      reg_write_o       <= 1'b0;
      bus_err_o         <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_o        <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      valid_o   <= 1'b0;
      bus_err_o <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_o <= 1'b0;
`endif
      timer_q <= (state_q == ACCESS) ? timer_q + 32'd1 : 32'h0;
      if (accept) begin
        if (is_mem && !misaligned) begin
          cmd_addr_q        <= alu_result_i;
          cmd_we_q          <= is_store;
          cmd_be_q          <= is_store ? st_be : 4'b1111;
          cmd_wdata_q       <= is_store ? st_wdata : 32'h0;
          cmd_funct3_q      <= funct3_i;
          pend_pcsrc_q      <= pcsrc_i;
          pend_offset_q     <= offset_i;
          pend_mem_to_reg_q <= mem_to_reg_i;
          pend_rd_q         <= rd_i;
          pend_reg_write_q  <= reg_write_i;
        end else begin
          valid_o      <= 1'b1;
          data_read_o  <= 32'h0;
          alu_result_o <= alu_result_i;
          pcsrc_o      <= pcsrc_i;
          offset_o     <= offset_i;
          mem_to_reg_o <= mem_to_reg_i;
          rd_o         <= rd_i;
          reg_write_o  <= reg_write_i && !misaligned;
`ifdef MISALIGN_TRAP_EN
          misalign_o   <= misaligned;
`endif
        end
      end
      if (ack_hit || timeout_hit) begin
        valid_o      <= 1'b1;
        data_read_o  <= (ack_hit && !cmd_we_q) ? load_data : 32'h0;
        alu_result_o <= cmd_addr_q;
        pcsrc_o      <= pend_pcsrc_q;
        offset_o     <= pend_offset_q;
        mem_to_reg_o <= pend_mem_to_reg_q;
        rd_o         <= pend_rd_q;
        reg_write_o  <= ack_hit && pend_reg_write_q;
        bus_err_o    <= timeout_hit;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_memaccess.sv
// Self-checking bench for pipeline_memaccess: writeback scoreboard fed by a spec-level model,
// plus directed literal checks on handshake timing, store encoding and load extension.
module tb_pipeline_memaccess;

  localparam int TIMEOUT = 16;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [31:0] alu_result_i = 32'h0;
  logic [31:0] store_data_i = 32'h0;
  logic [2:0]  funct3_i = 3'b000;
  logic        mem_read_i = 1'b0;
  logic        mem_write_i = 1'b0;
  logic [31:0] pcsrc_i = 32'h0;
  logic [31:0] offset_i = 32'h0;
  logic [1:0]  mem_to_reg_i = 2'b00;
  logic [4:0]  rd_i = 5'd0;
  logic        reg_write_i = 1'b0;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_ack_i = 1'b0;
  logic [31:0] dmem_rdata_i = 32'h0;
  logic        valid_o, reg_write_o, bus_err_o;
  logic [31:0] data_read_o, alu_result_o, pcsrc_o, offset_o;
  logic [1:0]  mem_to_reg_o;
  logic [4:0]  rd_o;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_o;
`endif

  pipeline_memaccess #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_o),
    .alu_result_i(alu_result_i), .store_data_i(store_data_i), .funct3_i(funct3_i),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .pcsrc_i(pcsrc_i),
    .offset_i(offset_i), .mem_to_reg_i(mem_to_reg_i), .rd_i(rd_i), .reg_write_i(reg_write_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o), .dmem_ack_i(dmem_ack_i),
    .dmem_rdata_i(dmem_rdata_i), .valid_o(valid_o), .data_read_o(data_read_o),
    .alu_result_o(alu_result_o), .pcsrc_o(pcsrc_o), .offset_o(offset_o),
    .mem_to_reg_o(mem_to_reg_o), .rd_o(rd_o), .reg_write_o(reg_write_o),
    .bus_err_o(bus_err_o)
`ifdef MISALIGN_TRAP_EN
    , .misalign_o(misalign_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [31:0] off;
    logic [1:0]  m2r;
    logic [4:0]  rd;
    logic        rw;
    logic        berr;
  } wb_t;

  wb_t exp_q[$];
  int  checks_total = 0;
  int  checks_passed = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic int access_bytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  // Load result from the RV32I rules: pick the naturally aligned lane, then extend.
  function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
    int n, off;
    logic [31:0] mask, raw;
    n = access_bytes(f3);
    if (n == 0 || (f3[2] && n == 4)) return 32'h0;
    off  = int'(addr[1:0]) & ~(n - 1);
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    raw  = (word >> (8 * off)) & mask;
    if (!f3[2] && n < 4 && raw[8 * n - 1]) raw = raw | ~mask;
    return raw;
  endfunction

  function automatic logic [3:0] be_model(input logic [2:0] f3, input logic [31:0] addr);
    int n, off;
    logic [31:0] m;
    n   = access_bytes(f3);
    off = int'(addr[1:0]) & ~(n - 1);
    m   = ((32'd1 << n) - 32'd1) << off;
    return m[3:0];
  endfunction

  function automatic logic [31:0] wdata_model(input logic [2:0] f3, input logic [31:0] d);
    case (access_bytes(f3))
      1:       return {24'h0, d[7:0]} * 32'h0101_0101;
      2:       return {16'h0, d[15:0]} * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  // Every writeback pulse must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (!reset_i && valid_o) begin
      if (exp_q.size() == 0) checkOutput("unexpected valid_o", 32'(valid_o), 32'd0);
      else begin
        wb_t e;
        e = exp_q.pop_front();
        checkOutput("wb data_read", data_read_o, e.data);
        checkOutput("wb alu_result", alu_result_o, e.alu);
        checkOutput("wb pcsrc", pcsrc_o, e.pc);
        checkOutput("wb offset", offset_o, e.off);
        checkOutput("wb mem_to_reg", 32'(mem_to_reg_o), 32'(e.m2r));
        checkOutput("wb rd", 32'(rd_o), 32'(e.rd));
        checkOutput("wb reg_write", 32'(reg_write_o), 32'(e.rw));
        checkOutput("wb bus_err", 32'(bus_err_o), 32'(e.berr));
      end
    end
  end

  task automatic drive_cmd(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] sdata, input logic [4:0] rd);
    valid_i      = 1'b1;
    mem_read_i   = rd_en;
    mem_write_i  = wr_en;
    funct3_i     = f3;
    alu_result_i = addr;
    store_data_i = sdata;
    pcsrc_i      = 32'h1000 + 32'(rd);
    offset_i     = 32'hFFFF_F000 | 32'(rd);
    mem_to_reg_i = 2'b01;
    rd_i         = rd;
    reg_write_i  = 1'b1;
  endtask

  task automatic clear_cmd();
    valid_i     = 1'b0;
    mem_read_i  = 1'b0;
    mem_write_i = 1'b0;
  endtask

  // One memory op; ack_cycle = ACCESS cycle in which ack is returned, 0 = never (timeout).
  task automatic applyStimulus(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] sdata,
                               input logic [31:0] rword, input int ack_cycle, input logic [4:0] rd);
    wb_t e;
    int  wait_cycles, req_cnt, low_cnt;
    logic is_store;
    is_store    = wr_en && !rd_en;
    wait_cycles = (ack_cycle == 0) ? TIMEOUT : ack_cycle;
    req_cnt     = 0;
    low_cnt     = 0;
    e.data = (ack_cycle != 0 && !is_store) ? load_model(f3, addr, rword) : 32'h0;
    e.alu  = addr;
    e.pc   = 32'h1000 + 32'(rd);
    e.off  = 32'hFFFF_F000 | 32'(rd);
    e.m2r  = 2'b01;
    e.rd   = rd;
    e.rw   = (ack_cycle != 0);
    e.berr = (ack_cycle == 0);
    exp_q.push_back(e);
    checkOutput("ready before accept", 32'(ready_o), 32'd1);
    drive_cmd(rd_en, wr_en, f3, addr, sdata, rd);
    @(negedge clk_i);
    clear_cmd();
    checkOutput("dmem_addr", dmem_addr_o, addr & 32'hFFFF_FFFC);
    checkOutput("dmem_we", 32'(dmem_we_o), 32'(is_store));
    if (is_store) begin
      checkOutput("dmem_be", 32'(dmem_be_o), 32'(be_model(f3, addr)));
      checkOutput("dmem_wdata", dmem_wdata_o, wdata_model(f3, sdata));
    end
    for (int k = 1; k <= wait_cycles; k++) begin
      if (dmem_req_o) req_cnt++;
      if (!ready_o) low_cnt++;
      if (k == ack_cycle) begin
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = rword;
      end
      @(negedge clk_i);
      dmem_ack_i = 1'b0;
    end
    checkOutput("req cycles", 32'(req_cnt), 32'(wait_cycles));
    checkOutput("ready low cycles", 32'(low_cnt), 32'(wait_cycles));
    checkOutput("valid after access", 32'(valid_o), 32'd1);
    checkOutput("req dropped", 32'(dmem_req_o), 32'd0);
    checkOutput("ready restored", 32'(ready_o), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset behaviour
    repeat (3) @(negedge clk_i);
    checkOutput("reset ready", 32'(ready_o), 32'd0);
    checkOutput("reset valid", 32'(valid_o), 32'd0);
    checkOutput("reset req", 32'(dmem_req_o), 32'd0);
    checkOutput("reset alu_result", alu_result_o, 32'h0);
    checkOutput("reset data_read", data_read_o, 32'h0);
    reset_i = 1'b0;
    @(negedge clk_i);
    checkOutput("ready after reset", 32'(ready_o), 32'd1);

    // Three back-to-back ALU ops
    for (int i = 0; i < 3; i++) begin
      wb_t e;
      drive_cmd(1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 5'(i + 1));
      e = '{data: 32'h0, alu: 32'h1234, pc: 32'h1000 + 32'(i + 1),
            off: 32'hFFFF_F000 | 32'(i + 1), m2r: 2'b01, rd: 5'(i + 1), rw: 1'b1, berr: 1'b0};
      exp_q.push_back(e);
      @(negedge clk_i);
      checkOutput("alu valid each cycle", 32'(valid_o), 32'd1);
      checkOutput("alu no req", 32'(dmem_req_o), 32'd0);
    end
    clear_cmd();
    @(negedge clk_i);
    checkOutput("valid is a pulse", 32'(valid_o), 32'd0);

    // Loads: LB with 4 wait cycles, then each extension/lane case
    applyStimulus(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 4, 5'd5);
    checkOutput("LB literal", data_read_o, 32'hFFFF_FF80);
    applyStimulus(1'b1, 1'b0, 3'b100, 32'h101, 32'h0, 32'h1234_5678, 1, 5'd6);
    checkOutput("LBU literal", data_read_o, 32'h0000_0056);
    applyStimulus(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h8001_0000, 2, 5'd7);
    checkOutput("LH literal", data_read_o, 32'hFFFF_8001);
    applyStimulus(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h8001_0000, 1, 5'd8);
    checkOutput("LHU literal", data_read_o, 32'h0000_8001);
    applyStimulus(1'b1, 1'b1, 3'b010, 32'h200, 32'h0, 32'hCAFE_F00D, 1, 5'd9);
    checkOutput("LW read+write as load", data_read_o, 32'hCAFE_F00D);
    applyStimulus(1'b1, 1'b0, 3'b011, 32'h204, 32'h0, 32'hFFFF_FFFF, 1, 5'd10);
    checkOutput("funct3 011 zero", data_read_o, 32'h0);

    // Stores
    applyStimulus(1'b0, 1'b1, 3'b001, 32'h22, 32'h0000_ABCD, 32'h0, 2, 5'd11);
    applyStimulus(1'b0, 1'b1, 3'b000, 32'h21, 32'h0000_005A, 32'h0, 1, 5'd12);
    applyStimulus(1'b0, 1'b1, 3'b010, 32'h40, 32'h1357_9BDF, 32'h0, 1, 5'd13);
    checkOutput("store data_read zero", data_read_o, 32'h0);
    drive_cmd(1'b0, 1'b1, 3'b001, 32'h22, 32'h0000_ABCD, 5'd14);
    @(negedge clk_i);
    clear_cmd();
    checkOutput("SH be literal", 32'(dmem_be_o), 32'h0000_000C);
    checkOutput("SH wdata literal", dmem_wdata_o, 32'hABCD_ABCD);
    checkOutput("SH we literal", 32'(dmem_we_o), 32'd1);
    exp_q.push_back('{data: 32'h0, alu: 32'h22, pc: 32'h100E, off: 32'hFFFF_F00E,
                      m2r: 2'b01, rd: 5'd14, rw: 1'b1, berr: 1'b0});
    dmem_ack_i = 1'b1;
    @(negedge clk_i);
    dmem_ack_i = 1'b0;

    // Timeout with no ack
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'h0, 0, 5'd15);
    checkOutput("timeout bus_err", 32'(bus_err_o), 32'd1);
    checkOutput("timeout reg_write", 32'(reg_write_o), 32'd0);
    @(negedge clk_i);
    checkOutput("bus_err is a pulse", 32'(bus_err_o), 32'd0);

    // Reset while ACCESS, then a late ack must be ignored
    drive_cmd(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 5'd16);
    @(negedge clk_i);
    clear_cmd();
    @(negedge clk_i);
    checkOutput("req mid access", 32'(dmem_req_o), 32'd1);
    reset_i = 1'b1;
    @(negedge clk_i);
    checkOutput("req drops on reset", 32'(dmem_req_o), 32'd0);
    reset_i = 1'b0;
    @(negedge clk_i);
    checkOutput("ready after mid reset", 32'(ready_o), 32'd1);
    dmem_ack_i   = 1'b1;
    dmem_rdata_i = 32'h5555_5555;
    @(negedge clk_i);
    dmem_ack_i = 1'b0;
    checkOutput("late ack ignored", 32'(valid_o), 32'd0);
    checkOutput("late ack no req", 32'(dmem_req_o), 32'd0);

    // LW at a misaligned address
`ifdef MISALIGN_TRAP_EN
    drive_cmd(1'b1, 1'b0, 3'b010, 32'h2, 32'h0, 5'd17);
    exp_q.push_back('{data: 32'h0, alu: 32'h2, pc: 32'h1011, off: 32'hFFFF_F011,
                      m2r: 2'b01, rd: 5'd17, rw: 1'b0, berr: 1'b0});
    @(negedge clk_i);
    clear_cmd();
    checkOutput("misalign no req", 32'(dmem_req_o), 32'd0);
    checkOutput("misalign flag", 32'(misalign_o), 32'd1);
    checkOutput("misalign reg_write", 32'(reg_write_o), 32'd0);
    @(negedge clk_i);
`else
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h2, 32'h0, 32'hDEAD_BEEF, 1, 5'd17);
    checkOutput("LW 0x2 word at 0x0", data_read_o, 32'hDEAD_BEEF);
`endif

    repeat (2) @(negedge clk_i);
    checkOutput("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
